// File: rtl/spi_duty_pwm.sv
// spi_duty_pwm: slew-limited PWM generator fed by SPI duty words, with a link-loss watchdog
module spi_duty_pwm #(
    parameter int PERIOD          = 2800,
    parameter int STEP            = 16,
    parameter int TIMEOUT_PERIODS = 500
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] rxd_data,
    input  logic        rxd_flag,
    input  logic        enable,
    output logic        pwm_out,
    output logic [15:0] duty_cur,
    output logic        period_tick,
    output logic        timeout
);
    typedef enum logic [1:0] {IDLE, RUN, TMO} state_t;

    localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int WW = $clog2(TIMEOUT_PERIODS + 1);

    state_t          state, state_next;
    logic [CW-1:0]   cnt;
    logic [WW-1:0]   wd;
    logic [15:0]     target, target_in, ramp;
    logic            expire;

    assign period_tick = (state != IDLE) && (cnt == CW'(PERIOD - 1));
    assign target_in   = (rxd_data > 16'(PERIOD)) ? 16'(PERIOD) : rxd_data;
    assign expire      = (state == RUN) && period_tick && !rxd_flag && (wd >= WW'(TIMEOUT_PERIODS - 1));

    // next duty value: jump to target when within one step, otherwise move one step toward it
    always_comb
        ramp = (target > duty_cur) ? ((target - duty_cur <= 16'(STEP)) ? target : duty_cur + 16'(STEP))
                                   : ((duty_cur - target <= 16'(STEP)) ? target : duty_cur - 16'(STEP));

    // next state: enable drop always wins, a new word revives a timed-out link
    always_comb begin
        state_next = state;
        if (!enable)
            state_next = IDLE;
        else if (state == IDLE)
            state_next = RUN;
        else if (state == TMO && rxd_flag)
            state_next = RUN;
        else if (expire)
            state_next = TMO;
    end

    // state register
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_next;

    // period counter, duty ramp, watchdog, target latch and registered outputs
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            cnt      <= '0;
            wd       <= '0;
            target   <= '0;
            duty_cur <= '0;
            pwm_out  <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            timeout <= (state_next == TMO);
            if (expire)
                target <= '0;
            else if (rxd_flag)
                target <= target_in;
            if (!enable || state == IDLE) begin
                cnt      <= '0;
                wd       <= '0;
                duty_cur <= '0;
                pwm_out  <= 1'b0;
            end else begin
                cnt     <= period_tick ? '0 : cnt + 1'b1;
                pwm_out <= 16'(cnt) < duty_cur;
                if (period_tick)
                    duty_cur <= ramp;
                if (rxd_flag)
                    wd <= '0;
                else if (period_tick && wd != WW'(TIMEOUT_PERIODS))
                    wd <= wd + 1'b1;
            end
        end
endmodule

// File: doc/spi_duty_pwm.md
SPI_DUTY_PWM -- requirements
Module: spi_duty_pwm

Interface
REQ-001 Parameter PERIOD, default 2800: PWM period in clk cycles; also the maximum legal duty value.
REQ-002 Parameter STEP, default 16: maximum duty change applied per PWM period (slew limit).
REQ-003 Parameter TIMEOUT_PERIODS, default 500: number of PWM periods without a new word before the watchdog trips.
REQ-004 clk  input  1  single system clock; all logic SHALL be on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 rxd_data  input  16  duty word from the upstream SPI receiver; valid when rxd_flag=1.
REQ-007 rxd_flag  input  1  one-cycle strobe marking a new rxd_data word.
REQ-008 enable  input  1  run enable; 0 forces the output stage idle.
REQ-009 pwm_out  output  1  registered PWM output, active high.
REQ-010 duty_cur  output  16  duty value currently applied to the comparator.
REQ-011 period_tick  output  1  one-cycle pulse on the last cycle of each PWM period.
REQ-012 timeout  output  1  high while the watchdog state is TIMEOUT.

Function
REQ-013 The block SHALL keep a period counter cnt running 0..PERIOD-1 and wrapping to 0 while state is not IDLE; in IDLE cnt SHALL hold 0.
REQ-014 period_tick SHALL be 1 exactly in cycles where cnt==PERIOD-1 and state is not IDLE.
REQ-015 On rxd_flag=1 the block SHALL latch target = min(rxd_data, PERIOD) on the next edge, in any state; values above PERIOD SHALL be clamped to PERIOD.
REQ-016 duty_cur SHALL change only on edges where period_tick=1: if |target-duty_cur|<=STEP then duty_cur=target, else duty_cur moves STEP toward target.
REQ-017 If rxd_flag and period_tick coincide, the ramp SHALL use the old target; the new target SHALL take effect at the following period_tick.
REQ-018 pwm_out SHALL be registered as (state!=IDLE && cnt<duty_cur), one clk of latency; duty_cur=0 gives constant 0; duty_cur=PERIOD gives constant 1.
REQ-019 States: IDLE, RUN, TIMEOUT.
REQ-020 IDLE->RUN when enable=1; RUN/TIMEOUT->IDLE when enable=0, taking effect on the next edge regardless of period position.
REQ-021 Entering IDLE SHALL clear cnt, duty_cur, the watchdog count and pwm_out; target SHALL be retained.
REQ-022 In RUN, a watchdog count SHALL increment on each period_tick and clear on each rxd_flag; when it reaches TIMEOUT_PERIODS, state SHALL go to TIMEOUT.
REQ-023 On entry to TIMEOUT, target SHALL be forced to 0, so duty_cur ramps down at STEP per period.
REQ-024 TIMEOUT->RUN on rxd_flag=1, with the new target latched per REQ-015 and the watchdog cleared.
REQ-025 If rxd_flag and watchdog expiry coincide, rxd_flag SHALL win: state stays RUN and the watchdog is cleared.
REQ-026 The watchdog count SHALL saturate and never wrap.
REQ-027 timeout SHALL be a registered decode of state==TIMEOUT.

Reset
REQ-028 While rst_n=0: pwm_out=0, duty_cur=0, period_tick=0, timeout=0, cnt=0, target=0, watchdog=0, state=IDLE.
REQ-029 After rst_n rises, the block SHALL take its first action on the first clk edge with enable=1.
REQ-030 Asserting rst_n mid-period SHALL force REQ-028 values immediately, without waiting for a clk edge.

Verification (PERIOD=100, STEP=10, TIMEOUT_PERIODS=4)
REQ-031 Steady ramp: enable=1, send rxd_data=35 -> duty_cur reads 10, 20, 30, 35 at successive period_ticks, then pwm_out is high 35 of every 100 cycles.
REQ-032 Clamp and extremes: send 5000 -> target=100, and pwm_out is constant 1 once ramped; send 0 -> pwm_out is constant 0 once ramped.
REQ-033 Watchdog: send 50, then no flags -> timeout=1 after the 4th period_tick, and duty_cur then falls 10 per period to 0; a flag with 20 -> timeout=0 and duty ramps to 20.
REQ-034 Coincidence: rxd_flag in a period_tick cycle -> ramp uses the old target, and the new target applies one period later; rxd_flag on the expiry tick -> timeout stays 0.
REQ-035 Enable drop: enable=0 at cnt=37 -> next edge pwm_out=0, cnt=0, duty_cur=0; re-enable -> duty_cur ramps again toward the retained target.
REQ-036 Async reset: rst_n low mid-high-pulse -> pwm_out=0 before the next clk edge, with all REQ-028 values held until release.
